// File: rtl/tnn_loader_pkg.sv
// tnn_loader_pkg: shared state encoding, default sizes and index-width helper for the feature loader
package tnn_loader_pkg;
  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;
  localparam int FEAT_W_DEF = 3;
  localparam int NUM_FEATURES_DEF = 6;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/tnn_frame_buf.sv
// tnn_frame_buf: one frame register {data, idx, state} stepped from a caller-chosen base snapshot
module tnn_frame_buf
  import tnn_loader_pkg::*;
#(
  parameter int NF = NUM_FEATURES_DEF,
  parameter int FW = FEAT_W_DEF,
  parameter int IW = idx_w(NF),
  parameter int SW = NF * FW + IW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [FW-1:0] data_i,
  input  logic          last_i,
  input  logic [SW-1:0] base_i,
  output logic [SW-1:0] snap_o,
  output logic          err_o
);
  localparam logic [IW-1:0] LAST = IW'(NF - 1);
  logic [SW-1:0]    snap_q;
  logic [NF*FW-1:0] data_d;
  logic [IW-1:0]    idx_c, idx_d;
  state_t           st_c, st_d;
  // base_i lets the top hand this buffer another buffer's contents (shadow promotion)
  always_comb begin
    {data_d, idx_c} = base_i[SW-1:2];
    st_c = state_t'(base_i[1:0]);
    if (clr_i) begin
      idx_c = '0;
      st_c = FILL;
    end
    idx_d = idx_c;
    st_d = st_c;
    err_o = 1'b0;
    if (wr_i && st_c != HOLD) begin
      if (st_c == FILL) data_d[idx_c*FW +: FW] = data_i;
      idx_d = st_c == FILL ? idx_c + IW'(1) : '0;
      if (last_i) begin
        idx_d = '0;
        st_d = (st_c == FILL && idx_c == LAST) ? HOLD : FILL;
        err_o = st_c == FILL && idx_c != LAST;
      end else if (st_c == FILL && idx_c == LAST) begin
        st_d = DRAIN;
        err_o = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) snap_q <= rst ? '0 : {data_d, idx_d, st_d};
  assign snap_o = snap_q;
endmodule

// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: serial feature stream to parallel frame loader; TNN_LOADER_DBUF_EN adds a shadow buffer
module tnn_feature_loader
  import tnn_loader_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_W-1:0]              s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_FEATURES*FEAT_W-1:0] m_features,
  output logic                           err_len,
  output logic [CNT_W-1:0]               frame_cnt
);
  localparam int IW = idx_w(NUM_FEATURES);
  localparam int DW = NUM_FEATURES * FEAT_W;
  localparam int SW = DW + IW + 2;
  logic [SW-1:0]    p_snap;
  logic             p_err, s_err, p_hold, acc, dlv, err_len_q;
  logic [CNT_W-1:0] frame_cnt_q;
  assign p_hold = p_snap[1:0] == HOLD;
  assign m_valid = p_hold;
  assign m_features = p_snap[SW-1 -: DW];
  assign dlv = m_valid & m_ready;
  assign acc = s_valid & s_ready;
`ifdef TNN_LOADER_DBUF_EN
  logic [SW-1:0] s_snap;
  logic          s_hold;
  assign s_hold = s_snap[1:0] == HOLD;
  assign s_ready = !(p_hold && s_hold);
  // on delivery the primary restarts from the shadow, absorbing any beat arriving that same cycle
  tnn_frame_buf #(.NF(NUM_FEATURES), .FW(FEAT_W)) u_pri (
    .clk(clk), .rst(rst), .clr_i(1'b0), .wr_i(acc && (!p_hold || dlv)), .data_i(s_data),
    .last_i(s_last), .base_i(dlv ? s_snap : p_snap), .snap_o(p_snap), .err_o(p_err)
  );
  tnn_frame_buf #(.NF(NUM_FEATURES), .FW(FEAT_W)) u_shd (
    .clk(clk), .rst(rst), .clr_i(dlv), .wr_i(acc && p_hold && !dlv), .data_i(s_data),
    .last_i(s_last), .base_i(s_snap), .snap_o(s_snap), .err_o(s_err)
  );
`else
  assign s_ready = !p_hold;
  assign s_err = 1'b0;
  tnn_frame_buf #(.NF(NUM_FEATURES), .FW(FEAT_W)) u_pri (
    .clk(clk), .rst(rst), .clr_i(dlv), .wr_i(acc), .data_i(s_data),
    .last_i(s_last), .base_i(p_snap), .snap_o(p_snap), .err_o(p_err)
  );
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_len_q <= p_err | s_err;
      if (dlv) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end
  assign err_len = err_len_q;
  assign frame_cnt = frame_cnt_q;
endmodule
